timer_delay_counter: RTL and testbench



---
 rtl/timer_delay_counter_if.sv | 24 ++
 rtl/timer_delay_counter.sv | 71 +++++++
 tb/tb_timer_delay_counter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/timer_delay_counter_if.sv
// Control/status bundle between the timer FSM and the delay counter datapath.
// With TIMER_PROTO_CHECK_EN defined the bundle also carries the sticky proto_err flag.
interface timer_delay_counter_if #(
    parameter int DELAY_W = 4
);
    logic               data;
    logic               shift_ena;
    logic               counting;
    logic               done_counting;
    logic [DELAY_W-1:0] count;
`ifdef TIMER_PROTO_CHECK_EN
    logic               proto_err;

    modport master (output data, shift_ena, counting,
                    input  done_counting, count, proto_err);
    modport slave  (input  data, shift_ena, counting,
                    output done_counting, count, proto_err);
`else
    modport master (output data, shift_ena, counting,
                    input  done_counting, count);
    modport slave  (input  data, shift_ena, counting,
                    output done_counting, count);
`endif
endinterface

// File: rtl/timer_delay_counter.sv
// Delay counter: shifts in a serial delay value, then times (delay+1)*TICKS_PER_UNIT cycles.
// Optional protocol checker enabled by defining TIMER_PROTO_CHECK_EN.
module timer_delay_counter #(
    parameter int DELAY_W        = 4,
    parameter int TICKS_PER_UNIT = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    timer_delay_counter_if.slave  tmr
);
    localparam int             SUB_W   = $clog2(TICKS_PER_UNIT);
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_UNIT - 1);

    logic [DELAY_W-1:0] r_delay;
    logic [SUB_W-1:0]   r_sub;
    logic               w_done;

    // Shift has priority over counting; any non-counting cycle reloads a full unit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_delay <= '0;
            r_sub   <= SUB_MAX;
        end else if (tmr.shift_ena) begin
            r_delay <= {r_delay[DELAY_W-2:0], tmr.data};
            r_sub   <= SUB_MAX;
        end else if (tmr.counting) begin
            if (r_sub != '0) begin
                r_sub <= r_sub - SUB_W'(1);
            end else if (r_delay != '0) begin
                r_delay <= r_delay - DELAY_W'(1);
                r_sub   <= SUB_MAX;
            end
        end else begin
            r_sub <= SUB_MAX;
        end
    end

    assign w_done            = tmr.counting && (r_delay == '0) && (r_sub == '0);
    assign tmr.done_counting = w_done;
    assign tmr.count         = r_delay;

`ifdef TIMER_PROTO_CHECK_EN
    logic [2:0] r_shift_cnt;
    logic       r_counting_d;
    logic       r_proto_err;

    // Shift count restarts when a counting episode ends; it saturates rather than wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift_cnt  <= '0;
            r_counting_d <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_counting_d <= tmr.counting;
            if (tmr.shift_ena && tmr.counting) begin
                r_proto_err <= 1'b1;
            end
            if (tmr.counting && !r_counting_d && (r_shift_cnt != 3'(DELAY_W))) begin
                r_proto_err <= 1'b1;
            end
            if (r_counting_d && !tmr.counting) begin
                r_shift_cnt <= '0;
            end else if (tmr.shift_ena && (r_shift_cnt != 3'd7)) begin
                r_shift_cnt <= r_shift_cnt + 3'd1;
            end
        end
    end

    assign tmr.proto_err = r_proto_err;
`endif
endmodule

// File: tb/tb_timer_delay_counter.sv
// Scoreboard bench for timer_delay_counter (DELAY_W=4, TICKS_PER_UNIT=4), directed plus random.
module tb_timer_delay_counter;
    localparam int DW = 4;
    localparam int T  = 4;

    typedef struct {
        logic          done;
        logic [DW-1:0] count;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t exp_q[$];

    // Reference model: units left, cycles elapsed in the current unit, protocol tracking.
    int m_units = 0;
    int m_elapsed = 0;
    int m_shifts = 0;
    bit m_prev_cnt = 0;
    bit m_err = 0;

    timer_delay_counter_if #(.DELAY_W(DW)) tmr();

    timer_delay_counter #(.DELAY_W(DW), .TICKS_PER_UNIT(T)) dut (
        .clk   (clk),
        .reset (reset),
        .tmr   (tmr.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    endtask

    task automatic step(input bit r, input bit sh, input bit cn, input bit d);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; tmr.shift_ena = sh; tmr.counting = cn; tmr.data = d;
        e.done  = cn && (m_units == 0) && (m_elapsed == T - 1);
        e.count = DW'(m_units);
        e.err   = m_err;
        exp_q.push_back(e);
        if (r) begin
            m_units = 0; m_elapsed = 0; m_shifts = 0; m_prev_cnt = 0; m_err = 0;
        end else begin
            if (sh && cn) m_err = 1;
            if (cn && !m_prev_cnt && m_shifts != DW) m_err = 1;
            if (m_prev_cnt && !cn) m_shifts = 0;
            else if (sh && m_shifts < 7) m_shifts++;
            m_prev_cnt = cn;
            if (sh) begin
                m_units = (m_units * 2 + int'(d)) % (1 << DW);
                m_elapsed = 0;
            end else if (cn) begin
                if (m_elapsed < T - 1) m_elapsed++;
                else if (m_units > 0) begin
                    m_units--;
                    m_elapsed = 0;
                end
            end else begin
                m_elapsed = 0;
            end
        end
    endtask

    task automatic shift_n(input int val, input int n);
        for (int i = n - 1; i >= 0; i--) step(0, 1, 0, val[i]);
    endtask

    task automatic interval(input string nm, input int req);
        int n = 0;
        for (int i = 1; i <= 200 && n == 0; i++) begin
            step(0, 0, 1, 0);
            #1;
            if (tmr.done_counting === 1'b1) n = i;
        end
        check(nm, n, req);
    endtask

    // Monitor: every cycle the DUT outputs are compared against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("done_counting", int'(tmr.done_counting), int'(e.done));
                check("count", int'(tmr.count), int'(e.count));
`ifdef TIMER_PROTO_CHECK_EN
                check("proto_err", int'(tmr.proto_err), int'(e.err));
`endif
            end
        end
    end

    initial begin
        reset = 1'b1; tmr.shift_ena = 1'b0; tmr.counting = 1'b0; tmr.data = 1'b0;
        repeat (2) @(posedge clk);
        step(1, 0, 0, 0);
        // Delay 10: done on the 44th counting cycle, held while counting stays high.
        shift_n(10, 4);
        interval("t1_interval", 44);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        // Delay 0: done on the 4th cycle, no underflow while held.
        shift_n(0, 4);
        interval("t2_interval", 4);
        repeat (3) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        // Delay 3 interrupted after 6 cycles, resumed for the remaining 12.
        shift_n(3, 4);
        repeat (6) step(0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0);
        interval("t3_resume", 12);
        step(0, 0, 0, 0);
        // Reset in the middle of a delay-5 interval.
        shift_n(5, 4);
        repeat (7) step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        repeat (3) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        // Shift and counting together: shift wins, protocol error is sticky.
        step(1, 0, 0, 0);
        step(0, 1, 1, 1);
        repeat (3) step(0, 0, 0, 0);
        // Short shift sequence vs. exact-width sequence before counting.
        step(1, 0, 0, 0);
        shift_n(6, 3);
        repeat (3) step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        shift_n(6, 4);
        repeat (3) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bit r, sh, cn;
            r  = ($urandom_range(0, 99) < 2);
            sh = ($urandom_range(0, 99) < 25);
            cn = ($urandom_range(0, 99) < 55);
            if (sh && cn && $urandom_range(0, 9) != 0) cn = 0;
            step(r, sh, cn, 1'($urandom_range(0, 1)));
        end
        step(0, 0, 0, 0);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
